// File: rtl/ps2_key_display.sv
// PS/2 scancode history driving 2*NUM_BYTES hex seven-segment digits.
// Define PS2_BREAK_FILTER_EN to drop break sequences (F0 xx) before they reach the history.
module ps2_key_display #(
   parameter int NUM_BYTES      = 4,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int BREAK_TIMEOUT  = 1000000
) (
   input  logic                      clock,
   input  logic                      resetn,
   input  logic                      key_pressed,
   input  logic [7:0]                key_data,
   input  logic                      clear,
   output logic [14*NUM_BYTES-1:0]   seg,
   output logic [7:0]                last_key,
   output logic [15:0]               key_count
);

   localparam logic INVERT = (SEG_ACTIVE_LOW != 0);
   localparam int   SEG_W  = 14 * NUM_BYTES;

   if (NUM_BYTES < 1 || NUM_BYTES > 4) begin : g_bad_depth
      $error("ps2_key_display: NUM_BYTES must be 1..4");
   end
   if (BREAK_TIMEOUT < 2) begin : g_bad_timeout
      $error("ps2_key_display: BREAK_TIMEOUT must be >= 2");
   end

   logic                   accept;
   logic [7:0]             hist_reg [NUM_BYTES];
   logic [7:0]             hist_next [NUM_BYTES];
   logic [NUM_BYTES-1:0]   valid_reg;
   logic [7:0]             last_key_reg;
   logic [15:0]            key_count_reg;
   logic [SEG_W-1:0]       seg_reg;
   logic [SEG_W-1:0]       seg_next;

`ifdef PS2_BREAK_FILTER_EN
   localparam int         TW         = $clog2(BREAK_TIMEOUT) + 1;
   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_BREAK   = 1'b1;

   logic [0:0]    state_reg;
   logic [TW-1:0] timer_reg;

   always_comb begin
      accept = key_pressed && (state_reg == ST_IDLE) && (key_data != 8'hF0);
   end

   // The byte following F0 is swallowed; the timer abandons a break whose second byte never arrives.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_reg <= ST_IDLE;
         timer_reg <= '0;
      end else if (clear) begin
         state_reg <= ST_IDLE;
         timer_reg <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (key_pressed && key_data == 8'hF0) begin
                  state_reg <= ST_BREAK;
                  timer_reg <= '0;
               end
            end
            default: begin
               if (key_pressed) begin
                  state_reg <= ST_IDLE;
               end else if (timer_reg == TW'(BREAK_TIMEOUT - 1)) begin
                  state_reg <= ST_IDLE;
               end else begin
                  timer_reg <= timer_reg + TW'(1);
               end
            end
         endcase
      end
   end
`else
   always_comb begin
      accept = key_pressed;
   end
`endif

   always_comb begin
      for (int k = NUM_BYTES - 1; k >= 1; k--) begin
         hist_next[k] = hist_reg[k-1];
      end
      hist_next[0] = key_data;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int k = 0; k < NUM_BYTES; k++) begin
            hist_reg[k] <= 8'h00;
         end
         valid_reg     <= '0;
         last_key_reg  <= 8'h00;
         key_count_reg <= 16'h0000;
      end else if (clear) begin
         for (int k = 0; k < NUM_BYTES; k++) begin
            hist_reg[k] <= 8'h00;
         end
         valid_reg     <= '0;
         last_key_reg  <= 8'h00;
         key_count_reg <= 16'h0000;
      end else if (accept) begin
         for (int k = 0; k < NUM_BYTES; k++) begin
            hist_reg[k] <= hist_next[k];
         end
         valid_reg     <= {valid_reg, 1'b1};
         last_key_reg  <= key_data;
         if (key_count_reg != 16'hFFFF) begin
            key_count_reg <= key_count_reg + 16'd1;
         end
      end
   end

   function automatic logic [6:0] hex_glyph(input logic [3:0] n);
      logic [6:0] g;
      case (n)
         4'h0: g = 7'h3F;
         4'h1: g = 7'h06;
         4'h2: g = 7'h5B;
         4'h3: g = 7'h4F;
         4'h4: g = 7'h66;
         4'h5: g = 7'h6D;
         4'h6: g = 7'h7D;
         4'h7: g = 7'h07;
         4'h8: g = 7'h7F;
         4'h9: g = 7'h6F;
         4'hA: g = 7'h77;
         4'hB: g = 7'h7C;
         4'hC: g = 7'h39;
         4'hD: g = 7'h5E;
         4'hE: g = 7'h79;
         default: g = 7'h71;
      endcase
      return g;
   endfunction

   // Empty slots decode to "no segments lit" before polarity is applied.
   for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_slot
      logic [6:0] lo_on;
      logic [6:0] hi_on;
      assign lo_on = valid_reg[gi] ? hex_glyph(hist_reg[gi][3:0]) : 7'h00;
      assign hi_on = valid_reg[gi] ? hex_glyph(hist_reg[gi][7:4]) : 7'h00;
      assign seg_next[14*gi +: 7]   = lo_on ^ {7{INVERT}};
      assign seg_next[14*gi+7 +: 7] = hi_on ^ {7{INVERT}};
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         seg_reg <= {SEG_W{INVERT}};
      end else begin
         seg_reg <= seg_next;
      end
   end

   assign seg       = seg_reg;
   assign last_key  = last_key_reg;
   assign key_count = key_count_reg;

endmodule

// File: tb/tb_ps2_key_display.sv
// Randomised scoreboard bench for ps2_key_display against a queue-based history model.
// Follows PS2_BREAK_FILTER_EN the same way the design does.
module tb_ps2_key_display;

   localparam int NB = 4;
   localparam int TO = 8;
   localparam int W  = 14 * NB;

   logic          clock = 1'b0;
   logic          resetn = 1'b1;
   logic          key_pressed = 1'b0;
   logic [7:0]    key_data = 8'h00;
   logic          clear = 1'b0;
   logic [W-1:0]  seg;
   logic [7:0]    last_key;
   logic [15:0]   key_count;

   ps2_key_display #(
      .NUM_BYTES      (NB),
      .SEG_ACTIVE_LOW (1),
      .BREAK_TIMEOUT  (TO)
   ) dut (
      .clock       (clock),
      .resetn      (resetn),
      .key_pressed (key_pressed),
      .key_data    (key_data),
      .clear       (clear),
      .seg         (seg),
      .last_key    (last_key),
      .key_count   (key_count)
   );

   always #5 clock = ~clock;

   int edge_cnt = 0;
   always @(posedge clock) edge_cnt = edge_cnt + 1;

   typedef struct {
      int            due;
      string         tag;
      logic [W-1:0]  seg;
      logic [7:0]    lk;
      logic [15:0]   cnt;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: newest byte at the front of the queue.
   logic [7:0] m_hist[$];
   logic [7:0] m_last = 8'h00;
   int         m_cnt = 0;
   bit         m_brk = 0;
   int         m_brk_edge = 0;

   logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   function automatic logic [W-1:0] render();
      logic [W-1:0] r;
      logic [7:0]   b;
      r = '1;
      for (int k = 0; k < NB; k++) begin
         if (k < m_hist.size()) begin
            b = m_hist[k];
            r[14*k +: 7]   = ~glyph_tab[b[3:0]];
            r[14*k+7 +: 7] = ~glyph_tab[b[7:4]];
         end
      end
      return r;
   endfunction

   task automatic model_reset();
      m_hist.delete();
      m_last = 8'h00;
      m_cnt  = 0;
      m_brk  = 0;
   endtask

   task automatic model_accept(input logic [7:0] d);
      m_hist.push_front(d);
      if (m_hist.size() > NB) void'(m_hist.pop_back());
      m_last = d;
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
   endtask

   // One clock: drive inputs, let edge N happen, update the model, queue what must be visible before edge N+1.
   task automatic step(input bit kp, input logic [7:0] d, input bit clr, input bit rst,
                       input bit chk, input string tag);
      logic [W-1:0] seg_now;
      if (rst) begin
         @(negedge clock);
         #1;
         resetn = 1'b0;
      end
      key_pressed = kp;
      key_data    = d;
      clear       = clr;
      @(posedge clock);
      #1;
      if (rst) begin
         model_reset();
         seg_now = render();
      end else begin
         seg_now = render();
         if (clr) begin
            model_reset();
         end else if (kp) begin
`ifdef PS2_BREAK_FILTER_EN
            if (m_brk) begin
               m_brk = 0;
            end else if (d == 8'hF0) begin
               m_brk = 1;
               m_brk_edge = edge_cnt;
            end else begin
               model_accept(d);
            end
`else
            model_accept(d);
`endif
         end else begin
`ifdef PS2_BREAK_FILTER_EN
            if (m_brk && (edge_cnt - m_brk_edge) == TO) m_brk = 0;
`endif
         end
      end
      if (chk) sb.push_back('{edge_cnt, tag, seg_now, m_last, m_cnt[15:0]});
      if (rst) resetn = 1'b1;
      key_pressed = 1'b0;
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0, 1, tag);
   endtask

   // Monitor: every queued expectation whose edge has come is compared on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         while (sb.size() > 0 && sb[0].due <= edge_cnt) begin
            e = sb.pop_front();
            n_cmp++;
            if (seg !== e.seg || last_key !== e.lk || key_count !== e.cnt) begin
               n_bad++;
               $display("FAIL %s edge %0d: got seg=%h last_key=%h key_count=%h, required seg=%h last_key=%h key_count=%h",
                        e.tag, e.due, seg, last_key, key_count, e.seg, e.lk, e.cnt);
            end else begin
               $display("ok   %s edge %0d: seg=%h last_key=%h key_count=%h", e.tag, e.due, seg, last_key, key_count);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] seq5 [5] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24};
      logic [7:0] d;
      bit         kp;
      bit         clr;

      step(0, 8'h00, 0, 1, 1, "reset");
      idle(10, "reset_idle");

      step(1, 8'h1C, 0, 0, 1, "strobe_1C");
      idle(2, "show_1C");

      for (int i = 0; i < 5; i++) step(1, seq5[i], 0, 0, 1, "b2b");
      idle(2, "b2b_show");

      step(0, 8'h00, 1, 0, 1, "clear");
      step(1, 8'h1C, 0, 0, 1, "brk_seq");
      step(1, 8'hF0, 0, 0, 1, "brk_seq");
      step(1, 8'h1C, 0, 0, 1, "brk_seq");
      idle(2, "brk_show");

      step(1, 8'hF0, 0, 0, 1, "timeout_f0");
      idle(TO + 5, "timeout_wait");
      step(1, 8'h25, 0, 0, 1, "timeout_25");
      idle(2, "timeout_show");

      step(1, 8'hF0, 0, 0, 1, "edge_f0");
      idle(TO - 1, "edge_wait");
      step(1, 8'h3A, 0, 0, 1, "edge_key");
      step(1, 8'hE0, 0, 0, 1, "e0_key");
      idle(2, "edge_show");

      for (int i = 0; i < 4; i++) step(1, 8'h40 + 8'(i), 0, 0, 1, "fill");
      step(1, 8'h55, 1, 0, 1, "clear_vs_key");
      idle(2, "clear_show");

      for (int i = 0; i < 300; i++) begin
         kp  = ($urandom_range(0, 1) == 1);
         d   = ($urandom_range(0, 3) == 0) ? 8'hF0 : 8'($urandom_range(0, 255));
         clr = ($urandom_range(0, 31) == 0);
         step(kp, d, clr, 0, 1, "random");
      end

      step(1, 8'h11, 0, 0, 1, "pre_rst");
      step(1, 8'hF0, 0, 0, 1, "rst_in_brk");
      step(1, 8'h77, 0, 1, 1, "rst_pulse");
      idle(2, "post_rst");
      step(1, 8'h1C, 0, 0, 1, "post_rst_1C");
      idle(2, "post_rst_show");

      step(0, 8'h00, 1, 0, 1, "sat_clear");
      for (int i = 0; i < 65540; i++) begin
         d = 8'($urandom_range(0, 8'hEF));
         step(1, d, 0, 0, (i % 4096 == 0) || (i > 65530), "saturate");
      end
      idle(2, "sat_hold");

      repeat (3) @(posedge clock);
      #1;
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d expectations never compared, required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
